if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RV32I CPU, directly upstream of the decode/control stage.
- Owns the PC register and issues single-outstanding requests to instruction memory over a valid/ready handshake.
- Captures the returned word into the IF/ID pipeline register, which feeds opcode, funct3 and funct7 to decode.
- Accepts PC redirects from EX (branch taken, JAL, JALR) and stall/flush from the hazard unit.

---
 rtl/if_stage_pkg.sv | 10 +
 rtl/if_stage_if_id_reg.sv | 34 +++
 rtl/if_stage.sv | 83 ++++++++
 tb/tb_if_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared state encodings and constants for the fetch stage.
package if_stage_pkg;
   typedef enum logic [1:0] {
      IF_ST_FETCH = 2'd0,
      IF_ST_WAIT  = 2'd1,
      IF_ST_DROP  = 2'd2
   } if_state_e;
   localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; load beats flush, stall holds a live entry.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(IF_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              load,
   input  logic [31:0]       d_instr,
   input  logic [ADDR_W-1:0] d_pc,
   output logic              free,
   output logic              valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc
);
   assign free = !valid || !stall;
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= INSTR_NOP;
         pc    <= RESET_PC;
      end else if (load && free) begin
         valid <= 1'b1;
         instr <= d_instr;
         pc    <= d_pc;
      end else if (flush) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage, PC + single-outstanding imem FSM + IF/ID register.
// Define IF_PERF_CNT_EN to add fetch/drop performance counters.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              id_stall,
   input  logic              id_flush,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   output logic              imem_rsp_ready,
   input  logic [31:0]       imem_rdata,
   output logic              id_valid,
   output logic [31:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_drop_cnt
`endif
);
   if_state_e         state;
   logic [ADDR_W-1:0] pc, req_pc, redir_pc;
   logic              free, load, drop;
   assign redir_pc       = redirect_pc & ~ADDR_W'(3);
   assign imem_req_valid = state == IF_ST_FETCH;
   assign imem_addr      = pc & ~ADDR_W'(3);
   // A redirect in WAIT consumes the in-flight word even while IF/ID is stalled.
   assign imem_rsp_ready = state == IF_ST_DROP || (state == IF_ST_WAIT && (free || redirect_valid));
   assign load           = state == IF_ST_WAIT && imem_rsp_valid && !redirect_valid;
   assign drop           = imem_rsp_valid && (state == IF_ST_DROP || (state == IF_ST_WAIT && redirect_valid));
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IF_ST_FETCH;
         pc     <= RESET_PC;
         req_pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc    <= redir_pc;
         state <= imem_req_valid ? (imem_req_ready ? IF_ST_DROP : IF_ST_FETCH)
                                 : (imem_rsp_valid ? IF_ST_FETCH : IF_ST_DROP);
      end else if (imem_req_valid) begin
         if (imem_req_ready) begin
            req_pc <= imem_addr;
            pc     <= pc + ADDR_W'(4);
            state  <= IF_ST_WAIT;
         end
      end else if (imem_rsp_valid && imem_rsp_ready) begin
         state <= IF_ST_FETCH;
      end
   end
   if_id_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .stall   (id_stall),
      .flush   (id_flush || redirect_valid),
      .load    (load),
      .d_instr (imem_rdata),
      .d_pc    (req_pc),
      .free    (free),
      .valid   (id_valid),
      .instr   (id_instr),
      .pc      (id_pc)
   );
`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_drop_cnt  <= '0;
      end else begin
         perf_fetch_cnt <= perf_fetch_cnt + 32'(load && free);
         perf_drop_cnt  <= perf_drop_cnt + 32'(drop);
      end
   end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a single-outstanding memory model.
module tb_if_stage;
   import if_stage_pkg::*;
   logic        clk = 1'b0, rst = 1'b1;
   logic        redirect_valid = 1'b0, id_stall = 1'b0, id_flush = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid, imem_rsp_ready;
   logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
   logic        id_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif
   logic        pend = 1'b0, stale = 1'b0, rsp_en = 1'b1;
   logic [31:0] paddr = '0;
   logic [63:0] exp_q[$];
   logic [31:0] req_q[$];
   int          checks = 0, failures = 0, loads_m = 0, drops_m = 0;
   logic        pv = 1'b0;
   logic [31:0] ppc = '0, pins = '0;

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hA5C3_0013;
   endfunction

   assign imem_rsp_valid = pend && rsp_en;
   assign imem_rdata     = word(paddr);

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .id_flush       (id_flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_ready (imem_rsp_ready),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_drop_cnt  (perf_drop_cnt)
`endif
   );

   // One clock: memory model updates after the edge, then load monitor at negedge.
   task automatic step();
      logic        rf, qf, rdv;
      logic [31:0] a;
      logic [63:0] e;
      #1;
      rf  = imem_rsp_valid && imem_rsp_ready;
      qf  = imem_req_valid && imem_req_ready;
      rdv = redirect_valid;
      a   = imem_addr;
      @(posedge clk);
      #1;
      if (rst) begin
         pend  = 1'b0;
         stale = 1'b0;
      end else begin
         if (rf) begin
            if (stale || rdv) drops_m++;
            else begin
               exp_q.push_back({paddr, word(paddr)});
               loads_m++;
            end
            pend = 1'b0;
         end
         if (qf) begin
            pend  = 1'b1;
            paddr = a;
            stale = rdv;
            req_q.push_back(a);
         end else if (rdv) stale = 1'b1;
      end
      @(negedge clk);
      if (rst) pv = 1'b0;
      else begin
         if (id_valid && (!pv || id_pc !== ppc || id_instr !== pins)) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL load_unexpected got pc=%h instr=%h want no load", id_pc, id_instr);
            end else begin
               e = exp_q.pop_front();
               if ({id_pc, id_instr} !== e) begin
                  failures++;
                  $display("FAIL load got pc=%h instr=%h want pc=%h instr=%h", id_pc, id_instr, e[63:32], e[31:0]);
               end
            end
         end
         pv   = id_valid;
         ppc  = id_pc;
         pins = id_instr;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      imem_req_ready = 1'b1;
      rsp_en = 1'b1;
      step();
      step();
      checks++;
      if ({imem_req_valid, imem_rsp_ready, id_valid} !== 3'b100) begin
         failures++;
         $display("FAIL reset_ctl got req_v/rsp_r/id_v=%b want 100", {imem_req_valid, imem_rsp_ready, id_valid});
      end
      checks++;
      if (imem_addr !== 32'h0 || id_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_pc got addr=%h id_pc=%h want 0/0", imem_addr, id_pc);
      end
      checks++;
      if (id_instr !== INSTR_NOP) begin
         failures++;
         $display("FAIL reset_instr got %h want %h", id_instr, INSTR_NOP);
      end
      rst = 1'b0;
      req_q.delete();
   endtask

   task automatic test_sequence();
      for (int i = 0; i < 3; i++) begin
         step();
         step();
         checks++;
         if (!id_valid || id_pc !== 32'(i * 4)) begin
            failures++;
            $display("FAIL seq_id got v=%b pc=%h want v=1 pc=%h", id_valid, id_pc, 32'(i * 4));
         end
      end
      checks++;
      if (req_q.size() < 3 || req_q[0] !== 32'h0 || req_q[1] !== 32'h4 || req_q[2] !== 32'h8) begin
         failures++;
         $display("FAIL seq_addr got %0d reqs first=%h want 0,4,8", req_q.size(), req_q.size() ? req_q[0] : 32'hx);
      end
   endtask

   task automatic test_stall();
      id_stall = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (imem_rsp_ready !== 1'b0 || id_pc !== 32'h8 || id_instr !== word(32'h8)) begin
            failures++;
            $display("FAIL stall_hold got rsp_r=%b pc=%h instr=%h want 0/%h/%h", imem_rsp_ready, id_pc, id_instr, 32'h8, word(32'h8));
         end
         step();
      end
      id_stall = 1'b0;
      #1;
      checks++;
      if (imem_rsp_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_release got rsp_r=%b want 1", imem_rsp_ready);
      end
      step();
      checks++;
      if (!id_valid || id_pc !== 32'hC) begin
         failures++;
         $display("FAIL stall_load got v=%b pc=%h want 1/%h", id_valid, id_pc, 32'hC);
      end
   endtask

   task automatic test_redirect_wait();
      rsp_en = 1'b0;
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0102;
      step();
      redirect_valid = 1'b0;
      checks++;
      if ({id_valid, imem_req_valid, imem_rsp_ready} !== 3'b001) begin
         failures++;
         $display("FAIL rdw_drop got id_v/req_v/rsp_r=%b want 001", {id_valid, imem_req_valid, imem_rsp_ready});
      end
      rsp_en = 1'b1;
      step();
      checks++;
      if (!imem_req_valid || imem_addr !== 32'h100 || id_valid) begin
         failures++;
         $display("FAIL rdw_refetch got req_v=%b addr=%h id_v=%b want 1/100/0", imem_req_valid, imem_addr, id_valid);
      end
      step();
      checks++;
      if (id_valid !== 1'b0) begin
         failures++;
         $display("FAIL rdw_wait got id_v=%b want 0", id_valid);
      end
      step();
      checks++;
      if (!id_valid || id_pc !== 32'h100) begin
         failures++;
         $display("FAIL rdw_load got v=%b pc=%h want 1/100", id_valid, id_pc);
      end
   endtask

   task automatic test_redirect_fetch();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h20;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (imem_addr !== 32'h20 || id_valid) begin
         failures++;
         $display("FAIL rdf_pc got addr=%h id_v=%b want 20/0", imem_addr, id_valid);
      end
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL rdf_drop got req_v=%b want 0", imem_req_valid);
      end
      step();
      checks++;
      if (!imem_req_valid || imem_addr !== 32'h200) begin
         failures++;
         $display("FAIL rdf_target got req_v=%b addr=%h want 1/200", imem_req_valid, imem_addr);
      end
      step();
      step();
      checks++;
      if (!id_valid || id_pc !== 32'h200) begin
         failures++;
         $display("FAIL rdf_load got v=%b pc=%h want 1/200", id_valid, id_pc);
      end
   endtask

   task automatic test_flush();
      step();
      id_flush = 1'b1;
      step();
      id_flush = 1'b0;
      checks++;
      if (!id_valid || id_pc !== 32'h204) begin
         failures++;
         $display("FAIL flush_load got v=%b pc=%h want 1/204", id_valid, id_pc);
      end
      id_flush = 1'b1;
      step();
      id_flush = 1'b0;
      checks++;
      if (id_valid || id_pc !== 32'h204) begin
         failures++;
         $display("FAIL flush_only got v=%b pc=%h want 0/204", id_valid, id_pc);
      end
      step();
      checks++;
      if (!id_valid || id_pc !== 32'h208 || req_q[$] !== 32'h208) begin
         failures++;
         $display("FAIL flush_seq got v=%b pc=%h last_req=%h want 1/208/208", id_valid, id_pc, req_q[$]);
      end
   endtask

   task automatic test_wrap();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_target got addr=%h want fffffffc", imem_addr);
      end
      step();
      step();
      checks++;
      if (id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL wrap_next got id_pc=%h addr=%h want fffffffc/0", id_pc, imem_addr);
      end
      step();
      step();
      checks++;
      if (!id_valid || id_pc !== 32'h0) begin
         failures++;
         $display("FAIL wrap_load got v=%b pc=%h want 1/0", id_valid, id_pc);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         redirect_valid = $urandom_range(0, 11) == 0;
         redirect_pc    = 32'h1000 + 32'($urandom_range(0, 1023));
         id_stall       = $urandom_range(0, 2) == 0;
         id_flush       = $urandom_range(0, 7) == 0;
         rsp_en         = $urandom_range(0, 3) != 0;
         imem_req_ready = $urandom_range(0, 3) != 0;
         #1;
         if (imem_req_valid) begin
            checks++;
            if (imem_addr[1:0] !== 2'b00) begin
               failures++;
               $display("FAIL align got addr=%h want low bits 00", imem_addr);
            end
         end
         step();
      end
      redirect_valid = 1'b0;
      id_stall = 1'b0;
      id_flush = 1'b0;
      rsp_en = 1'b1;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      end
`ifdef IF_PERF_CNT_EN
      checks++;
      if (perf_fetch_cnt !== 32'(loads_m) || perf_drop_cnt !== 32'(drops_m)) begin
         failures++;
         $display("FAIL perf got fetch=%0d drop=%0d want %0d/%0d", perf_fetch_cnt, perf_drop_cnt, loads_m, drops_m);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_stall();
      test_redirect_wait();
      test_redirect_fetch();
      test_flush();
      test_wrap();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
